mux_scan_ctrl: RTL and testbench

Sequential select generator and sampler that sits directly upstream of the `mux4to1` stage, on its select lines, and directly downstream of it, on its `out` line. On a start request it steps `s1:s0` through channels 0..3 and waits a programmable settle time after each select change. It then samples the mux output and presents the 4 captured bits as one word on a valid/ready handshake. Its job is to turn the combinational switch-level mux into a scanned 4-channel input port.

---
 rtl/mux_scan_ctrl.sv | 111 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scanned 4-channel input port: steps mux4to1 selects 0..3, samples each after SETTLE idle cycles,
// and offers the captured word on valid/ready. Define MUX_SCAN_CONT_EN for continuous rescanning.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for start
    // WAIT  | channel ch selected, counting down settle time, sample at cnt=0
    // DONE  | full word held on data/valid until handshake
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] ch_q,    ch_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] data_q,  data_d;
    logic       valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d    = 2'd0;
                    sel_d   = 2'd0;
                    cnt_d   = SETTLE_C;
                    data_d  = 4'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d[ch_q] = mux_out;
                    if (ch_q != 2'd3) begin
                        ch_d  = ch_q + 2'd1;
                        sel_d = ch_q + 2'd1;
                        cnt_d = SETTLE_C;
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ready) begin
                    valid_d = 1'b0;
                    sel_d   = 2'd0;
`ifdef MUX_SCAN_CONT_EN
                    // rescan immediately; start is only needed for the first scan
                    ch_d    = 2'd0;
                    cnt_d   = SETTLE_C;
                    state_d = WAIT;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s0    = sel_q[0];
    assign s1    = sel_q[1];
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: three instances (SETTLE=1,0,3), each driving a mux4to1 model.
module tb_mux_scan_ctrl;

    logic clk;
    logic rst_n;

    logic       start_a, ready_a, mux_a, s0_a, s1_a, valid_a, busy_a;
    logic [3:0] ins_a, data_a;
    logic       start_b, ready_b, mux_b, s0_b, s1_b, valid_b, busy_b;
    logic [3:0] ins_b, data_b;
    logic       start_c, ready_c, mux_c, s0_c, s1_c, valid_c, busy_c;
    logic [3:0] ins_c, data_c;

    int n_chk;
    int n_fail;
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    logic [3:0] q_c[$];

`ifdef MUX_SCAN_CONT_EN
    localparam logic BUSY_AFTER = 1'b1;
`else
    localparam logic BUSY_AFTER = 1'b0;
`endif

    mux_scan_ctrl #(.SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mux_out(mux_a), .s0(s0_a), .s1(s1_a),
        .data(data_a), .valid(valid_a), .ready(ready_a), .busy(busy_a));
    mux_scan_ctrl #(.SETTLE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mux_out(mux_b), .s0(s0_b), .s1(s1_b),
        .data(data_b), .valid(valid_b), .ready(ready_b), .busy(busy_b));
    mux_scan_ctrl #(.SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .mux_out(mux_c), .s0(s0_c), .s1(s1_c),
        .data(data_c), .valid(valid_c), .ready(ready_c), .busy(busy_c));

    assign mux_a = ins_a[{s1_a, s0_a}];
    assign mux_b = ins_b[{s1_b, s0_b}];
    assign mux_c = ins_c[{s1_c, s0_c}];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: a handshake happens at the next posedge whenever valid & ready at the negedge.
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            if (q_a.size() == 0) chk("a unexpected word", {28'd0, data_a}, 32'hFFFF_FFFF);
            else chk("a data", {28'd0, data_a}, {28'd0, q_a.pop_front()});
        end
    end
    always @(negedge clk) begin
        if (rst_n && valid_b && ready_b) begin
            if (q_b.size() == 0) chk("b unexpected word", {28'd0, data_b}, 32'hFFFF_FFFF);
            else chk("b data", {28'd0, data_b}, {28'd0, q_b.pop_front()});
        end
    end
    always @(negedge clk) begin
        if (rst_n && valid_c && ready_c) begin
            if (q_c.size() == 0) chk("c unexpected word", {28'd0, data_c}, 32'hFFFF_FFFF);
            else chk("c data", {28'd0, data_c}, {28'd0, q_c.pop_front()});
        end
    end

    task automatic pulse_start_a();
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
    endtask

    initial begin
        logic [1:0] sel_seq [8];
        sel_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        {start_a, start_b, start_c} = 3'b000;
        {ready_a, ready_b, ready_c} = 3'b000;
        ins_a = 4'b1101;
        ins_b = 4'b0110;
        ins_c = 4'b1010;
        #12;
        chk("rst sel", {30'd0, s1_a, s0_a}, 32'd0);
        chk("rst data", {28'd0, data_a}, 32'd0);
        chk("rst valid", {31'd0, valid_a}, 32'd0);
        chk("rst busy", {31'd0, busy_a}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // reset mid-scan (SETTLE=1), asserted between edges
        pulse_start_a();
        cyc(2);
        chk("mid sel", {30'd0, s1_a, s0_a}, 32'd1);
        chk("mid data", {28'd0, data_a}, 32'h1);
        chk("mid busy", {31'd0, busy_a}, 32'd1);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async sel", {30'd0, s1_a, s0_a}, 32'd0);
        chk("async data", {28'd0, data_a}, 32'd0);
        chk("async valid", {31'd0, valid_a}, 32'd0);
        chk("async busy", {31'd0, busy_a}, 32'd0);
        #1 rst_n = 1'b1;
        cyc(2);

`ifdef MUX_SCAN_CONT_EN
        // continuous: one start, valid every 9 cycles, i1 flip shows in the next word
        ready_a = 1'b1;
        q_a.push_back(4'b1101);
        q_a.push_back(4'b1111);
        pulse_start_a();
        cyc(8);
        chk("cont valid1", {31'd0, valid_a}, 32'd1);
        chk("cont data1", {28'd0, data_a}, 32'hD);
        cyc(1);
        chk("cont gap valid", {31'd0, valid_a}, 32'd0);
        chk("cont gap busy", {31'd0, busy_a}, 32'd1);
        chk("cont gap sel", {30'd0, s1_a, s0_a}, 32'd0);
        ins_a[1] = 1'b1;
        cyc(7);
        chk("cont pre valid2", {31'd0, valid_a}, 32'd0);
        cyc(1);
        chk("cont valid2", {31'd0, valid_a}, 32'd1);
        chk("cont data2", {28'd0, data_a}, 32'hF);
        cyc(1);
        ready_a = 1'b0;
        chk("cont busy held", {31'd0, busy_a}, 32'd1);
`else
        // basic scan with select sequence
        ready_a = 1'b1;
        q_a.push_back(4'b1101);
        pulse_start_a();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("basic sel %0d", j), {30'd0, s1_a, s0_a}, {30'd0, sel_seq[j]});
            chk($sformatf("basic valid %0d", j), {31'd0, valid_a}, 32'd0);
            cyc(1);
        end
        chk("basic valid", {31'd0, valid_a}, 32'd1);
        chk("basic data", {28'd0, data_a}, 32'hD);
        cyc(1);
        chk("basic post valid", {31'd0, valid_a}, 32'd0);
        chk("basic post busy", {31'd0, busy_a}, 32'd0);
        chk("basic post sel", {30'd0, s1_a, s0_a}, 32'd0);
        cyc(1);

        // backpressure, with a start pulse during DONE that must be dropped
        ready_a = 1'b0;
        q_a.push_back(4'b1101);
        pulse_start_a();
        cyc(8);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("bp valid %0d", b), {31'd0, valid_a}, 32'd1);
            chk($sformatf("bp data %0d", b), {28'd0, data_a}, 32'hD);
            start_a = (b == 1);
            cyc(1);
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        cyc(1);
        ready_a = 1'b0;
        chk("bp post valid", {31'd0, valid_a}, 32'd0);
        chk("bp post busy", {31'd0, busy_a}, 32'd0);
        cyc(1);
        chk("bp start not queued", {31'd0, busy_a}, 32'd0);
`endif

        // SETTLE=0: valid 4 cycles after accept
        q_b.push_back(4'b0110);
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        cyc(3);
        chk("s0 pre valid", {31'd0, valid_b}, 32'd0);
        cyc(1);
        chk("s0 valid", {31'd0, valid_b}, 32'd1);
        chk("s0 data", {28'd0, data_b}, 32'h6);
        ready_b = 1'b1;
        cyc(1);
        ready_b = 1'b0;
        chk("s0 post valid", {31'd0, valid_b}, 32'd0);
        chk("s0 post busy", {31'd0, busy_b}, {31'd0, BUSY_AFTER});

        // SETTLE=3: i2 glitches during settle, ends high before the sample edge
        q_c.push_back(4'b1110);
        start_c = 1'b1;
        cyc(1);
        start_c = 1'b0;
        cyc(8);
        chk("s3 sel ch2", {30'd0, s1_c, s0_c}, 32'd2);
        ins_c[2] = 1'b0;
        cyc(1);
        ins_c[2] = 1'b1;
        cyc(1);
        ins_c[2] = 1'b0;
        cyc(1);
        ins_c[2] = 1'b1;
        cyc(4);
        chk("s3 pre valid", {31'd0, valid_c}, 32'd0);
        cyc(1);
        chk("s3 valid", {31'd0, valid_c}, 32'd1);
        chk("s3 data", {28'd0, data_c}, 32'hE);
        ready_c = 1'b1;
        cyc(1);
        ready_c = 1'b0;
        chk("s3 post valid", {31'd0, valid_c}, 32'd0);
        chk("s3 post busy", {31'd0, busy_c}, {31'd0, BUSY_AFTER});

        cyc(2);
        chk("a queue drained", q_a.size(), 32'd0);
        chk("b queue drained", q_b.size(), 32'd0);
        chk("c queue drained", q_c.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
